// File: rtl/csr_redirect_forwarder.sv
// In-flight CSR write pipeline from EX to commit, with youngest-first forwarding
// of pending CSR values into the ID-stage redirect PC and csrr* read paths.
module csr_redirect_forwarder #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_csr_write,
   input  logic [ADDR_W-1:0] ex_csr_addr,
   input  logic [XLEN-1:0]   ex_csr_wdata,
   input  logic [2:0]        trap,
   output logic [ADDR_W-1:0] csr_read_addr,
   input  logic [XLEN-1:0]   csr_read_data,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]   rd_file_data,
   output logic [XLEN-1:0]   rd_data,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              redirect_hit,
   output logic              commit_we,
   output logic [ADDR_W-1:0] commit_addr,
   output logic [XLEN-1:0]   commit_data
);

   localparam logic [2:0] TRAP_NONE  = 3'b000;
   localparam logic [2:0] TRAP_ECALL = 3'b001;
   localparam logic [2:0] TRAP_UNIMP = 3'b010;
   localparam logic [2:0] TRAP_MRET  = 3'b011;
   localparam logic [2:0] TRAP_SRET  = 3'b100;

   localparam logic [ADDR_W-1:0] CSR_MEPC  = ADDR_W'(12'h341);
   localparam logic [ADDR_W-1:0] CSR_SEPC  = ADDR_W'(12'h141);
   localparam logic [ADDR_W-1:0] CSR_MTVEC = ADDR_W'(12'h305);

   logic [DEPTH-1:0]             r_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
   logic [DEPTH-1:0][XLEN-1:0]   r_data;

   logic                         w_exValid;
   logic [XLEN:0]                w_redirectLookup;
   logic [XLEN:0]                w_rdLookup;

   // Flush beats stall: the pipeline still advances, only the EX write is dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (flush || !stall) begin
         r_valid[0] <= ex_csr_write & ~flush;
         r_addr[0]  <= flush ? '0 : ex_csr_addr;
         r_data[0]  <= flush ? '0 : ex_csr_wdata;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_addr[i]  <= r_addr[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   always_comb begin
      csr_read_addr = CSR_MEPC;
      case (trap)
         TRAP_MRET:  csr_read_addr = CSR_MEPC;
         TRAP_SRET:  csr_read_addr = CSR_SEPC;
         TRAP_ECALL: csr_read_addr = CSR_MTVEC;
         TRAP_UNIMP: csr_read_addr = CSR_MTVEC;
         default:    csr_read_addr = CSR_MEPC;
      endcase
   end

   // Returns {hit, value}; oldest candidates are applied first so younger ones override.
   function automatic logic [XLEN:0] lookup(
      input logic [ADDR_W-1:0]             a,
      input logic [XLEN-1:0]               fileData,
      input logic                          exValid,
      input logic [ADDR_W-1:0]             exAddr,
      input logic [XLEN-1:0]               exData,
      input logic [DEPTH-1:0]              v,
      input logic [DEPTH-1:0][ADDR_W-1:0]  ad,
      input logic [DEPTH-1:0][XLEN-1:0]    d
   );
      logic [XLEN:0] res;
      res = {1'b0, fileData};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (v[i] && (ad[i] == a)) begin
            res = {1'b1, d[i]};
         end
      end
      if (exValid && (exAddr == a)) begin
         res = {1'b1, exData};
      end
      return res;
   endfunction

   assign w_exValid = ex_csr_write & ~flush;

   always_comb begin
      w_redirectLookup = lookup(csr_read_addr, csr_read_data, w_exValid, ex_csr_addr,
                                ex_csr_wdata, r_valid, r_addr, r_data);
      w_rdLookup       = lookup(rd_addr, rd_file_data, w_exValid, ex_csr_addr,
                                ex_csr_wdata, r_valid, r_addr, r_data);
   end

   assign redirect_pc  = (trap == TRAP_NONE) ? csr_read_data : w_redirectLookup[XLEN-1:0];
   assign redirect_hit = (trap != TRAP_NONE) & w_redirectLookup[XLEN];
   assign rd_data      = w_rdLookup[XLEN-1:0];

   assign commit_we    = r_valid[DEPTH-1] & ~stall;
   assign commit_addr  = r_addr[DEPTH-1];
   assign commit_data  = r_data[DEPTH-1];

endmodule

// File: tb/tb_csr_redirect_forwarder.sv
// Directed bench for csr_redirect_forwarder: immediate checks on the forwarding
// outputs plus a scoreboard queue of expected commits drained by a monitor.
module tb_csr_redirect_forwarder;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 2;
   localparam int ADDR_W = 12;

   logic              clk;
   logic              rstn;
   logic              stall;
   logic              flush;
   logic              ex_csr_write;
   logic [ADDR_W-1:0] ex_csr_addr;
   logic [XLEN-1:0]   ex_csr_wdata;
   logic [2:0]        trap;
   logic [ADDR_W-1:0] csr_read_addr;
   logic [XLEN-1:0]   csr_read_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [XLEN-1:0]   rd_file_data;
   logic [XLEN-1:0]   rd_data;
   logic [XLEN-1:0]   redirect_pc;
   logic              redirect_hit;
   logic              commit_we;
   logic [ADDR_W-1:0] commit_addr;
   logic [XLEN-1:0]   commit_data;

   int testsRun  = 0;
   int testsFail = 0;
   logic [ADDR_W+XLEN-1:0] expQ[$];

   csr_redirect_forwarder #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
      .ex_csr_write(ex_csr_write), .ex_csr_addr(ex_csr_addr), .ex_csr_wdata(ex_csr_wdata),
      .trap(trap), .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
      .rd_addr(rd_addr), .rd_file_data(rd_file_data), .rd_data(rd_data),
      .redirect_pc(redirect_pc), .redirect_hit(redirect_hit),
      .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented commit must match the oldest expected entry.
   always @(negedge clk) begin
      if (commit_we === 1'b1) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFail++;
            $display("[TB] FAIL unexpected_commit: got addr 0x%0h data 0x%0h expected none",
                     commit_addr, commit_data);
         end else begin
            logic [ADDR_W+XLEN-1:0] e;
            e = expQ.pop_front();
            checkOutput("commit_addr", XLEN'(commit_addr), XLEN'(e[ADDR_W+XLEN-1:XLEN]));
            checkOutput("commit_data", commit_data, e[XLEN-1:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d,
                                input logic [2:0] t, input logic [XLEN-1:0] fileData);
      ex_csr_write  = we;
      ex_csr_addr   = a;
      ex_csr_wdata  = d;
      trap          = t;
      csr_read_data = fileData;
      #1;
   endtask

   task automatic expectCommit(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
      expQ.push_back({a, d});
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; flush = 1'b0;
      ex_csr_write = 1'b0; ex_csr_addr = '0; ex_csr_wdata = '0;
      trap = 3'b000; csr_read_data = '0; rd_addr = '0; rd_file_data = '0;
      #2;
      checkOutput("reset_commit_we", XLEN'(commit_we), 0);
      checkOutput("reset_commit_addr", XLEN'(commit_addr), 0);
      checkOutput("reset_commit_data", commit_data, 0);
      #10;
      rstn = 1'b1;
      step();

      // 1: EX write forwards into the same-cycle mret redirect and the rd port
      rd_addr = 12'h341; rd_file_data = 32'h11;
      applyStimulus(1'b1, 12'h341, 32'h8000_0100, 3'b011, 32'h8000_0000);
      checkOutput("t1_read_addr", XLEN'(csr_read_addr), 32'h341);
      checkOutput("t1_redirect_pc", redirect_pc, 32'h8000_0100);
      checkOutput("t1_redirect_hit", XLEN'(redirect_hit), 1);
      checkOutput("t1_rd_data", rd_data, 32'h8000_0100);
      expectCommit(12'h341, 32'h8000_0100);
      step();
      applyStimulus(1'b0, '0, '0, 3'b000, 32'h0);
      repeat (3) step();

      // 2: youngest of two same-address slots wins; both commit in order
      applyStimulus(1'b1, 12'h341, 32'hA0, 3'b000, 32'h0);
      expectCommit(12'h341, 32'hA0);
      step();
      applyStimulus(1'b1, 12'h341, 32'hB0, 3'b000, 32'h0);
      expectCommit(12'h341, 32'hB0);
      step();
      applyStimulus(1'b0, '0, '0, 3'b011, 32'h1);
      checkOutput("t2_redirect_pc", redirect_pc, 32'hB0);
      checkOutput("t2_commit_first", commit_data, 32'hA0);
      step();
      checkOutput("t2_commit_second", commit_data, 32'hB0);
      checkOutput("t2_commit_we", XLEN'(commit_we), 1);
      step();
      applyStimulus(1'b0, '0, '0, 3'b000, 32'h0);
      checkOutput("t2_drained", XLEN'(commit_we), 0);
      step();

      // 3: ecall picks mtvec from slot0; unimp with nothing pending uses the file
      applyStimulus(1'b1, 12'h305, 32'h100, 3'b000, 32'h0);
      expectCommit(12'h305, 32'h100);
      step();
      rd_addr = 12'h141; rd_file_data = 32'h33;
      applyStimulus(1'b0, '0, '0, 3'b001, 32'h999);
      checkOutput("t3_read_addr", XLEN'(csr_read_addr), 32'h305);
      checkOutput("t3_redirect_pc", redirect_pc, 32'h100);
      checkOutput("t3_rd_data_file", rd_data, 32'h33);
      repeat (2) step();
      applyStimulus(1'b0, '0, '0, 3'b010, 32'h200);
      checkOutput("t3_unimp_addr", XLEN'(csr_read_addr), 32'h305);
      checkOutput("t3_unimp_pc", redirect_pc, 32'h200);
      checkOutput("t3_unimp_hit", XLEN'(redirect_hit), 0);
      applyStimulus(1'b0, '0, '0, 3'b000, 32'h1234);
      checkOutput("t3_none_addr", XLEN'(csr_read_addr), 32'h341);
      checkOutput("t3_none_pc", redirect_pc, 32'h1234);
      checkOutput("t3_none_hit", XLEN'(redirect_hit), 0);

      // 4: stalls hold the entry, EX still forwards under stall, commit once
      applyStimulus(1'b1, 12'h141, 32'h55, 3'b000, 32'h0);
      expectCommit(12'h141, 32'h55);
      step();
      stall = 1'b1;
      applyStimulus(1'b0, '0, '0, 3'b100, 32'h7);
      checkOutput("t4_stall_pc", redirect_pc, 32'h55);
      checkOutput("t4_stall_we0", XLEN'(commit_we), 0);
      step();
      applyStimulus(1'b1, 12'h141, 32'h66, 3'b100, 32'h7);
      checkOutput("t4_stall_ex_fwd", redirect_pc, 32'h66);
      step();
      stall = 1'b0;
      applyStimulus(1'b0, '0, '0, 3'b100, 32'h7);
      step();
      stall = 1'b1;
      #1;
      checkOutput("t4_stall_commit_slot", XLEN'(commit_we), 0);
      checkOutput("t4_stall_pc_slot1", redirect_pc, 32'h55);
      step();
      stall = 1'b0;
      #1;
      checkOutput("t4_release_we", XLEN'(commit_we), 1);
      checkOutput("t4_release_data", commit_data, 32'h55);
      step();
      checkOutput("t4_once", XLEN'(commit_we), 0);

      // 5: flushed EX write never forwards or commits
      flush = 1'b1;
      applyStimulus(1'b1, 12'h341, 32'h77, 3'b011, 32'h5000);
      checkOutput("t5_flush_pc", redirect_pc, 32'h5000);
      checkOutput("t5_flush_hit", XLEN'(redirect_hit), 0);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, '0, '0, 3'b011, 32'h5000);
      checkOutput("t5_next_pc", redirect_pc, 32'h5000);
      checkOutput("t5_next_hit", XLEN'(redirect_hit), 0);
      repeat (3) step();

      // 5b: flush still advances older slots, which commit normally
      applyStimulus(1'b1, 12'h340, 32'h1, 3'b000, 32'h0);
      expectCommit(12'h340, 32'h1);
      step();
      flush = 1'b1;
      applyStimulus(1'b1, 12'h340, 32'h2, 3'b000, 32'h0);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, '0, '0, 3'b000, 32'h0);
      checkOutput("t5b_commit_data", commit_data, 32'h1);
      repeat (3) step();

      // 6: async reset mid-cycle with a full pipeline
      applyStimulus(1'b1, 12'h305, 32'hC1, 3'b000, 32'h0);
      step();
      applyStimulus(1'b1, 12'h305, 32'hC2, 3'b000, 32'h0);
      step();
      applyStimulus(1'b1, 12'h305, 32'hC3, 3'b000, 32'h0);
      rstn = 1'b0;
      #1;
      checkOutput("t6_reset_we", XLEN'(commit_we), 0);
      checkOutput("t6_reset_addr", XLEN'(commit_addr), 0);
      checkOutput("t6_reset_data", commit_data, 0);
      step();
      applyStimulus(1'b0, '0, '0, 3'b001, 32'hABC);
      rstn = 1'b1;
      #1;
      checkOutput("t6_after_pc", redirect_pc, 32'hABC);
      checkOutput("t6_after_hit", XLEN'(redirect_hit), 0);
      repeat (4) step();

      checkOutput("scoreboard_empty", XLEN'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
